regfile_scan: RTL and testbench
===============================

Name: regfile_scan

Overview:
- Sequential reader for the CPU's 32x32 register file. On a start pulse it walks registers FIRST_REG..LAST_REG through one combinational read port.
- Each captured word is streamed out on a valid/ready interface for debug or dump logic, e.g. a UART transmitter or display driver.
- Sits beside the datapath and shares a regfile read port, selected by the debug mux outside this block.

Parameters:
- FIRST_REG, 1, first register index scanned (0..31).
- LAST_REG, 31, last register index scanned (FIRST_REG..31).

Ports:
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a scan; ignored while busy.
- abort  in  1  synchronous cancel of an active scan.
- rn  out  5  read address to the regfile read port.
- q  in  32  read data from the regfile; combinational function of rn, r0 reads 0.
- out_valid  out  1  out_data/out_idx hold a word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  32  captured register value.
- out_idx  out  5  index of the captured register.
- busy  out  1  scan in progress (any state except IDLE).
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (clrn=0, async): state=IDLE, idx=0, rn=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0. Applies immediately, also mid-scan. No done pulse is produced and no partial word is kept.
- All outputs are registered, except rn, which is decoded from state/idx: rn=idx in READ, 0 otherwise.
- States: IDLE, READ, SEND, FIN.
- IDLE, start=1 -> READ with idx=FIRST_REG.
- READ, one cycle: rn=idx. At the edge, out_data<=q, out_idx<=idx, out_valid<=1, and the state goes to SEND.
- SEND: hold out_valid, out_data and out_idx stable until out_ready=1. On the accepting edge out_valid<=0, then:
  - if idx==LAST_REG: go to FIN;
  - else: idx<=idx+1 and go to READ.
- FIN, one cycle: done=1 (registered pulse, high exactly one cycle), then IDLE with busy=0.
- Throughput: one word per 2 cycles when out_ready is held high.
- Latency: start edge to first out_valid = 2 edges.
- Boundaries:
  - The idx compare happens before the increment, so LAST_REG=31 never wraps to 0.
  - FIRST_REG==LAST_REG: exactly one word is sent, then done.
  - FIRST_REG=0: the word for r0 is sent as 0, because the regfile returns 0 for r0.
- Concurrent CPU write to register idx in the READ cycle: the captured value is the pre-write value, because the regfile updates on the same edge. This is acceptable and documented.
- abort=1 in any non-IDLE state: next state IDLE, out_valid<=0, no done. abort has priority over out_ready. abort in IDLE has no effect.
- start while busy: ignored. start and abort in the same IDLE cycle: start wins.
- out_ready while out_valid=0: ignored.
- Parameter check: elaboration error if FIRST_REG>LAST_REG or LAST_REG>31.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'd0, READ=2'd1, SEND=2'd2, FIN=2'd3;
  - NUM_REGS=32;
  - REG_AW=5;
  - WORD_W=32.
- No sub-module. The FSM, index counter and output register are one block, about 150 lines.

Test Plan:
1. Preload r1..r31 = 32'h100+i, out_ready=1, pulse start -> 31 words with out_idx 1..31 and out_data 32'h101..32'h11F, one every 2 cycles. done is high exactly 1 cycle after word 31; busy falls the same cycle done falls.
2. Backpressure: out_ready low for 5 cycles on word r3 -> out_valid, out_data=32'h103 and out_idx=3 stay stable all 5 cycles, no word is skipped, and rn does not advance.
3. FIRST_REG=LAST_REG=31 with r31=32'hDEADBEEF -> single word out_idx=31, out_data=32'hDEADBEEF, then done. idx never wraps to 0.
4. Drive clrn low while the bench is holding word r10 (out_valid high) -> all outputs 0 immediately, without waiting for a clock. After release there is no done pulse, and a new start restarts from r1.
5. Assert abort during SEND of r5 -> IDLE next cycle, out_valid=0, done never asserts. A start pulse during the scan before the abort is ignored, and the sequence of words is unchanged.
6. CPU writes r7<=32'h55 on the same edge as the READ capture of r7 (old value 32'h107) -> out_data=32'h107. A following scan returns 32'h55.

Source files
------------

// File: rtl/regfile_scan_pkg.sv
// regfile_scan_pkg: shared state encoding and sizes for the register file scanner.
package regfile_scan_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_scan_if.sv
// regfile_scan_if: valid/ready word stream carrying a captured register and its index.
interface regfile_scan_if;
    import regfile_scan_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [REG_AW-1:0] out_idx;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        output out_ready
    );

endinterface

// File: rtl/regfile_scan.sv
// regfile_scan: walks registers FIRST_REG..LAST_REG through a shared combinational
// read port and streams each captured word out on a valid/ready interface.
// The regfile samples writes on the same edge as the capture, so a concurrent
// CPU write to the register being read yields its pre-write value.
module regfile_scan
    import regfile_scan_pkg::*;
#(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              start,
    input  logic              abort,
    output logic [REG_AW-1:0] rn,
    input  logic [WORD_W-1:0] q,
    regfile_scan_if.master    stream,
    output logic              busy,
    output logic              done
);

    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > NUM_REGS - 1) begin : g_param_check
        $error("regfile_scan: FIRST_REG/LAST_REG out of range");
    end

    localparam logic [REG_AW-1:0] FIRST_IDX = REG_AW'(FIRST_REG);
    localparam logic [REG_AW-1:0] LAST_IDX  = REG_AW'(LAST_REG);

    state_t            state;
    logic [REG_AW-1:0] idx;
    logic              out_valid_r;
    logic [WORD_W-1:0] out_data_r;
    logic [REG_AW-1:0] out_idx_r;

    assign stream.out_valid = out_valid_r;
    assign stream.out_data  = out_data_r;
    assign stream.out_idx   = out_idx_r;

    // The read address is only presented during READ so the shared port idles at r0.
    assign rn = (state == READ) ? idx : '0;

    // Scan FSM with index counter and registered stream/status outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            idx         <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        idx   <= FIRST_IDX;
                        busy  <= 1'b1;
                    end
                end
                READ: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        out_data_r  <= q;
                        out_idx_r   <= idx;
                        out_valid_r <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy        <= 1'b0;
                    end else if (stream.out_ready) begin
                        out_valid_r <= 1'b0;
                        // Compare before incrementing so LAST_REG=31 never wraps to r0.
                        if (idx == LAST_IDX) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= READ;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scan.sv
// tb_regfile_scan: scoreboard bench for regfile_scan. Expected words are queued
// when a scan is started; a negedge monitor pops and compares on each handshake.
module tb_regfile_scan;
    import regfile_scan_pkg::*;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start;
    logic        abort;
    logic [4:0]  rn;
    logic [31:0] q;
    logic        busy;
    logic        done;

    logic        start31;
    logic        abort31;
    logic [4:0]  rn31;
    logic [31:0] q31;
    logic        busy31;
    logic        done31;

    logic        cpu_we;
    logic [4:0]  cpu_wa;
    logic [31:0] cpu_wd;
    logic [31:0] mem [32];

    logic [31:0] model_regs [32];
    exp_t        exp_q [$];
    int          accept_cycles [$];
    int          done_expected = 0;
    int          last_accept_cycle = 0;
    int          cycle = 0;
    int          start_cycle = 0;
    int          tests_run = 0;
    int          tests_failed = 0;
    logic        prev_done = 1'b0;

    regfile_scan_if sif ();
    regfile_scan_if sif31 ();

    regfile_scan #(.FIRST_REG(1), .LAST_REG(31)) dut (
        .clk    (clk),
        .clrn   (clrn),
        .start  (start),
        .abort  (abort),
        .rn     (rn),
        .q      (q),
        .stream (sif.master),
        .busy   (busy),
        .done   (done)
    );

    regfile_scan #(.FIRST_REG(31), .LAST_REG(31)) dut31 (
        .clk    (clk),
        .clrn   (clrn),
        .start  (start31),
        .abort  (abort31),
        .rn     (rn31),
        .q      (q31),
        .stream (sif31.master),
        .busy   (busy31),
        .done   (done31)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency and throughput checks.
    always @(posedge clk) cycle <= cycle + 1;

    // Regfile storage: writes land on the clock edge, reads are combinational with r0 tied to 0.
    always @(posedge clk) if (cpu_we) mem[cpu_wa] <= cpu_wd;
    assign q   = (rn == 5'd0)   ? 32'd0 : mem[rn];
    assign q31 = (rn31 == 5'd0) ? 32'd0 : mem[rn31];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int a, input logic [31:0] d);
        cpu_we = 1'b1;
        cpu_wa = 5'(a);
        cpu_wd = d;
        tick();
        cpu_we = 1'b0;
        if (a != 0) model_regs[a] = d;
    endtask

    // A scan of r1..r31 should deliver each register's current contents in index order.
    task automatic issue_scan();
        accept_cycles.delete();
        for (int i = 1; i <= 31; i++)
            exp_q.push_back('{idx: 5'(i), data: model_regs[i]});
        done_expected++;
        start_cycle = cycle;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check_output("idle_timeout", 32'(busy), 32'd0);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        check_output("done_seen", 32'(done_expected), 32'd0);
    endtask

    task automatic wait_word(input logic [4:0] want, output bit found);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            tick();
            if (sif.out_valid && sif.out_idx == want) found = 1'b1;
        end
        if (!found) check_output("word_wait_timeout", 32'(want), 32'hFFFF_FFFF);
    endtask

    // Monitor: pop and compare on every accepted word, and police the done pulse.
    always @(negedge clk) begin
        if (clrn && sif.out_valid && sif.out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_word", 32'(sif.out_idx), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("word_idx", 32'(sif.out_idx), 32'(e.idx));
                check_output("word_data", sif.out_data, e.data);
            end
            accept_cycles.push_back(cycle);
            last_accept_cycle = cycle;
        end
        if (done) begin
            check_output("done_width", 32'(prev_done), 32'd0);
            if (done_expected == 0) begin
                check_output("unexpected_done", 32'(done), 32'd0);
            end else begin
                done_expected--;
                check_output("done_timing", 32'(cycle), 32'(last_accept_cycle + 1));
                check_output("busy_during_done", 32'(busy), 32'd1);
            end
        end
        if (prev_done && !done) check_output("busy_falls_with_done", 32'(busy), 32'd0);
        prev_done <= done;
    end

    initial begin
        bit found;
        int bad_gaps;
        int seen;

        clrn          = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        start31       = 1'b0;
        abort31       = 1'b0;
        cpu_we        = 1'b0;
        cpu_wa        = '0;
        cpu_wd        = '0;
        sif.out_ready   = 1'b0;
        sif31.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

        // Preload r1..r31 = 0x100+i while the scanner is held in reset.
        write_reg(0, 32'd0);
        for (int i = 1; i <= 31; i++) write_reg(i, 32'(32'h100 + i));

        check_output("reset_valid", 32'(sif.out_valid), 32'd0);
        check_output("reset_data", sif.out_data, 32'd0);
        check_output("reset_idx", 32'(sif.out_idx), 32'd0);
        check_output("reset_rn", 32'(rn), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        clrn = 1'b1;
        tick();

        $display("[TB] test 1: full scan, ready held high");
        sif.out_ready = 1'b1;
        issue_scan();
        wait_idle(200);
        check_output("t1_word_count", 32'(accept_cycles.size()), 32'd31);
        if (accept_cycles.size() > 0)
            check_output("t1_first_latency", 32'(accept_cycles[0]), 32'(start_cycle + 2));
        bad_gaps = 0;
        for (int i = 1; i < accept_cycles.size(); i++)
            if (accept_cycles[i] - accept_cycles[i-1] != 2) bad_gaps++;
        check_output("t1_throughput_gaps", 32'(bad_gaps), 32'd0);

        $display("[TB] test 2: backpressure on r3");
        issue_scan();
        wait_word(5'd3, found);
        if (found) begin
            sif.out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
                tick();
                check_output("t2_hold_valid", 32'(sif.out_valid), 32'd1);
                check_output("t2_hold_data", sif.out_data, 32'h103);
                check_output("t2_hold_idx", 32'(sif.out_idx), 32'd3);
                check_output("t2_hold_rn", 32'(rn), 32'd0);
            end
        end
        sif.out_ready = 1'b1;
        wait_idle(200);
        check_output("t2_word_count", 32'(accept_cycles.size()), 32'd31);

        $display("[TB] test 3: single register r31");
        write_reg(31, 32'hDEAD_BEEF);
        start31 = 1'b1;
        tick();
        start31 = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            if (sif31.out_valid) found = 1'b1;
            else tick();
        end
        check_output("t3_valid_seen", 32'(found), 32'd1);
        check_output("t3_idx", 32'(sif31.out_idx), 32'd31);
        check_output("t3_data", sif31.out_data, 32'hDEAD_BEEF);
        tick();
        check_output("t3_done", 32'(done31), 32'd1);
        tick();
        check_output("t3_done_low", 32'(done31), 32'd0);
        check_output("t3_busy_low", 32'(busy31), 32'd0);
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (sif31.out_valid || busy31) seen++;
        end
        check_output("t3_no_wrap", 32'(seen), 32'd0);

        $display("[TB] test 4: async reset while holding r10");
        issue_scan();
        wait_word(5'd10, found);
        sif.out_ready = 1'b0;
        tick();
        #2;
        clrn = 1'b0;
        #1;
        check_output("t4_async_valid", 32'(sif.out_valid), 32'd0);
        check_output("t4_async_data", sif.out_data, 32'd0);
        check_output("t4_async_idx", 32'(sif.out_idx), 32'd0);
        check_output("t4_async_busy", 32'(busy), 32'd0);
        check_output("t4_async_done", 32'(done), 32'd0);
        exp_q.delete();
        done_expected = 0;
        tick();
        tick();
        clrn = 1'b1;
        seen = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (done) seen++;
        end
        check_output("t4_no_done", 32'(seen), 32'd0);
        sif.out_ready = 1'b1;
        issue_scan();
        wait_idle(200);
        check_output("t4_word_count", 32'(accept_cycles.size()), 32'd31);

        $display("[TB] test 5: abort during r5, stray start ignored");
        issue_scan();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_word(5'd5, found);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("t5_valid_dropped", 32'(sif.out_valid), 32'd0);
        check_output("t5_busy_dropped", 32'(busy), 32'd0);
        exp_q.delete();
        done_expected = 0;
        seen = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (done || busy) seen++;
        end
        check_output("t5_no_done", 32'(seen), 32'd0);
        check_output("t5_word_count", 32'(accept_cycles.size()), 32'd4);

        $display("[TB] test 6: concurrent write to r7 during its read");
        issue_scan();
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (rn == 5'd7) found = 1'b1;
            else tick();
        end
        check_output("t6_read_r7_seen", 32'(found), 32'd1);
        cpu_we = 1'b1;
        cpu_wa = 5'd7;
        cpu_wd = 32'h55;
        tick();
        cpu_we = 1'b0;
        model_regs[7] = 32'h55;
        wait_idle(200);
        issue_scan();
        wait_idle(200);

        $display("[TB] test 7: random contents with random ready");
        for (int i = 1; i <= 31; i++) write_reg(i, $urandom);
        issue_scan();
        for (int n = 0; n < 1000 && busy; n++) begin
            sif.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        sif.out_ready = 1'b1;
        wait_idle(50);
        check_output("t7_word_count", 32'(accept_cycles.size()), 32'd31);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
